pipe_scheduler: RTL and testbench

//  Sequences the two scrolling pipe obstacles for the game: spawns them, scrolls them left at a fixed tick rate,

---
 rtl/pipe_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_pipe_scheduler.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_scheduler.sv
// rtl/pipe_scheduler.sv - two-pipe obstacle scheduler: spawn, scroll, recycle, score
// Ports:
//   Clk, reset (async active-low)
//   Start / Ack / Lose    FSM controls (IDLE->RUN, HALT->IDLE, RUN->HALT)
//   Bird_X                bird X position used for scoring
//   X_Edge0/1, Y_Edge0/1  pipe right edge and gap centre per pipe
//   Score                 saturating pass count
//   Tick                  one-cycle pulse on each scroll step
//   Q_Idle/Q_Run/Q_Halt   one-hot state outputs
module pipe_scheduler #(
  parameter int          SCREEN_W  = 640,
  parameter int          PIPE_W    = 40,
  parameter int          SPACING   = 320,
  parameter int          TICK_DIV  = 250000,
  parameter int          STEP      = 1,
  parameter int          GAP_MIN   = 120,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       Start,
  input  logic       Ack,
  input  logic       Lose,
  input  logic [9:0] Bird_X,
  output logic [9:0] X_Edge0,
  output logic [9:0] Y_Edge0,
  output logic [9:0] X_Edge1,
  output logic [9:0] Y_Edge1,
  output logic [7:0] Score,
  output logic       Tick,
  output logic       Q_Idle,
  output logic       Q_Run,
  output logic       Q_Halt
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
  localparam logic [9:0] X0_INIT = 10'(SCREEN_W + PIPE_W);
  localparam logic [9:0] X1_INIT = 10'(SCREEN_W + PIPE_W + SPACING);
  localparam logic [9:0] Y_INIT  = 10'(GAP_MIN);
  localparam logic [9:0] STEP_W  = 10'(STEP);
  localparam logic [9:0] SPACE_W = 10'(SPACING);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [9:0]    r_x0, r_x1, r_y0, r_y1;
  logic [7:0]    r_score;
  logic [7:0]    r_lfsr;
  logic          r_tick, r_q_idle, r_q_run, r_q_halt;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  logic       w_tick, w_rec0, w_rec1, w_pass0, w_pass1;
  logic [9:0] w_dec0, w_dec1, w_x0n, w_x1n, w_y0n, w_y1n;
  logic [7:0] w_lfsr1, w_lfsr2, w_lfsr_n, w_score_n;
  logic [8:0] w_score_sum;

  assign w_tick  = (r_cnt == CNT_MAX);
  assign w_rec0  = (r_x0 <= STEP_W);
  assign w_rec1  = (r_x1 <= STEP_W);
  assign w_dec0  = r_x0 - STEP_W;
  assign w_dec1  = r_x1 - STEP_W;
  assign w_lfsr1 = lfsr_next(r_lfsr);
  assign w_lfsr2 = lfsr_next(w_lfsr1);

  // A recycled pipe is placed SPACING behind the other pipe's post-step position.
  always_comb begin
    w_x0n    = w_dec0;
    w_x1n    = w_dec1;
    w_y0n    = r_y0;
    w_y1n    = r_y1;
    w_lfsr_n = r_lfsr;
    if (w_rec0 && w_rec1) begin
      w_x0n    = X0_INIT;
      w_x1n    = X1_INIT;
      w_y0n    = Y_INIT + {2'b00, w_lfsr1};
      w_y1n    = Y_INIT + {2'b00, w_lfsr2};
      w_lfsr_n = w_lfsr2;
    end else if (w_rec0) begin
      w_x0n    = w_dec1 + SPACE_W;
      w_y0n    = Y_INIT + {2'b00, w_lfsr1};
      w_lfsr_n = w_lfsr1;
    end else if (w_rec1) begin
      w_x1n    = w_dec0 + SPACE_W;
      w_y1n    = Y_INIT + {2'b00, w_lfsr1};
      w_lfsr_n = w_lfsr1;
    end
  end

  // A pipe scores when its right edge crosses the bird; recycling pipes never score.
  assign w_pass0     = !w_rec0 && (r_x0 > Bird_X) && (w_dec0 <= Bird_X);
  assign w_pass1     = !w_rec1 && (r_x1 > Bird_X) && (w_dec1 <= Bird_X);
  assign w_score_sum = {1'b0, r_score} + {8'd0, w_pass0} + {8'd0, w_pass1};
  assign w_score_n   = w_score_sum[8] ? 8'hFF : w_score_sum[7:0];

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_x0     <= X0_INIT;
      r_x1     <= X1_INIT;
      r_y0     <= Y_INIT;
      r_y1     <= Y_INIT;
      r_score  <= 8'd0;
      r_lfsr   <= LFSR_SEED;
      r_tick   <= 1'b0;
      r_q_idle <= 1'b1;
      r_q_run  <= 1'b0;
      r_q_halt <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tick <= 1'b0;
          r_cnt  <= '0;
          if (Start) begin
            r_state  <= S_RUN;
            r_x0     <= X0_INIT;
            r_x1     <= X1_INIT;
            r_y0     <= Y_INIT;
            r_y1     <= Y_INIT;
            r_score  <= 8'd0;
            r_q_idle <= 1'b0;
            r_q_run  <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_tick) begin
            r_cnt   <= '0;
            r_tick  <= 1'b1;
            r_x0    <= w_x0n;
            r_x1    <= w_x1n;
            r_y0    <= w_y0n;
            r_y1    <= w_y1n;
            r_lfsr  <= w_lfsr_n;
            r_score <= w_score_n;
          end else begin
            r_cnt  <= r_cnt + CW'(1);
            r_tick <= 1'b0;
          end
          // Lose wins over Start/Ack; a coincident tick update above still lands.
          if (Lose) begin
            r_state  <= S_HALT;
            r_cnt    <= '0;
            r_q_run  <= 1'b0;
            r_q_halt <= 1'b1;
          end
        end
        S_HALT: begin
          r_tick <= 1'b0;
          r_cnt  <= '0;
          if (Ack) begin
            r_state  <= S_IDLE;
            r_q_halt <= 1'b0;
            r_q_idle <= 1'b1;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_tick   <= 1'b0;
          r_cnt    <= '0;
          r_q_idle <= 1'b1;
          r_q_run  <= 1'b0;
          r_q_halt <= 1'b0;
        end
      endcase
    end
  end

  assign X_Edge0 = r_x0;
  assign X_Edge1 = r_x1;
  assign Y_Edge0 = r_y0;
  assign Y_Edge1 = r_y1;
  assign Score   = r_score;
  assign Tick    = r_tick;
  assign Q_Idle  = r_q_idle;
  assign Q_Run   = r_q_run;
  assign Q_Halt  = r_q_halt;

endmodule

// File: tb/tb_pipe_scheduler.sv
// tb/tb_pipe_scheduler.sv - directed bench for pipe_scheduler
module tb_pipe_scheduler;

  logic       clk = 1'b0;
  logic       rst_n, start, ack, lose;
  logic [9:0] bird_x;
  logic [9:0] x0, y0, x1, y1;
  logic [7:0] score;
  logic       tick, q_idle, q_run, q_halt;

  logic       s_rst_n, s_start;
  logic [9:0] s_bird;
  logic [9:0] s_x0, s_y0, s_x1, s_y1;
  logic [7:0] s_score;
  logic       s_tick, s_qi, s_qr, s_qh;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_scheduler #(.TICK_DIV(4)) dut (
    .Clk(clk), .reset(rst_n), .Start(start), .Ack(ack), .Lose(lose), .Bird_X(bird_x),
    .X_Edge0(x0), .Y_Edge0(y0), .X_Edge1(x1), .Y_Edge1(y1),
    .Score(score), .Tick(tick), .Q_Idle(q_idle), .Q_Run(q_run), .Q_Halt(q_halt)
  );

  // Tiny playfield so the score saturates within a short run.
  pipe_scheduler #(.SCREEN_W(8), .PIPE_W(2), .SPACING(5), .TICK_DIV(2)) dut_small (
    .Clk(clk), .reset(s_rst_n), .Start(s_start), .Ack(1'b0), .Lose(1'b0), .Bird_X(s_bird),
    .X_Edge0(s_x0), .Y_Edge0(s_y0), .X_Edge1(s_x1), .Y_Edge1(s_y1),
    .Score(s_score), .Tick(s_tick), .Q_Idle(s_qi), .Q_Run(s_qr), .Q_Halt(s_qh)
  );

  typedef struct {
    logic       start;
    logic       ack;
    logic       lose;
    logic [2:0] exp_q;   // {idle, run, halt}
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ticks(input int n);
    int seen = 0;
    int cyc  = 0;
    while (seen < n && cyc < n * 8 + 20) begin
      step();
      cyc++;
      if (tick) seen++;
    end
    if (seen < n) chk("tick_timeout", seen, n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    int frozen_errs;
    int n;
    logic [9:0] hx0, hx1, hy0, hy1;
    logic [7:0] hs;

    vecs[0]  = '{1'b0, 1'b0, 1'b1, 3'b100};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 3'b100};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 3'b010};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 3'b010};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 3'b010};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 3'b001};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 3'b001};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 3'b001};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 3'b100};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 3'b010};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 3'b001};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 3'b100};

    rst_n = 1'b0; s_rst_n = 1'b0;
    start = 1'b0; ack = 1'b0; lose = 1'b0; bird_x = 10'd0;
    s_start = 1'b0; s_bird = 10'd3;
    repeat (2) step();
    chk("reset_q", {q_idle, q_run, q_halt}, 3'b100);
    chk("reset_x0", x0, 680);
    chk("reset_x1", x1, 1000);
    rst_n = 1'b1; s_rst_n = 1'b1;
    step();

    start = 1'b1; s_start = 1'b1;
    step();
    start = 1'b0; s_start = 1'b0;
    chk("start_run", {q_idle, q_run, q_halt}, 3'b010);
    chk("start_tick0", tick, 0);

    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("first_tick_c%0d", i), tick, (i == 4) ? 1 : 0);
    end
    wait_ticks(9);
    chk("ten_ticks_x0", x0, 670);
    chk("ten_ticks_x1", x1, 990);

    gap = 0;
    do begin
      step();
      gap++;
    end while (!tick && gap < 20);
    chk("tick_period", gap, 4);

    wait_ticks(668);
    chk("pre_recycle_x0", x0, 1);
    chk("pre_recycle_x1", x1, 321);
    chk("pre_recycle_score", score, 0);

    bird_x = 10'd320;
    wait_ticks(1);
    chk("recycle_x1", x1, 320);
    chk("recycle_x0", x0, 640);
    chk("recycle_y0", y0, 194);
    chk("recycle_y1", y1, 120);
    chk("pass_score", score, 1);

    lose = 1'b1;
    step();
    lose = 1'b0;
    chk("lose_halt", {q_idle, q_run, q_halt}, 3'b001);
    hx0 = x0; hx1 = x1; hy0 = y0; hy1 = y1; hs = score;
    frozen_errs = 0;
    for (int i = 0; i < 100; i++) begin
      start = (i < 50);
      step();
      if (x0 !== hx0 || x1 !== hx1 || y0 !== hy0 || y1 !== hy1 || score !== hs || tick !== 1'b0 || q_halt !== 1'b1)
        frozen_errs++;
    end
    start = 1'b0;
    chk("halt_frozen_errs", frozen_errs, 0);
    chk("halt_score_held", hs, 1);

    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("ack_idle", {q_idle, q_run, q_halt}, 3'b100);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_q", {q_idle, q_run, q_halt}, 3'b010);
    chk("restart_x0", x0, 680);
    chk("restart_x1", x1, 1000);
    chk("restart_y0", y0, 120);
    chk("restart_score", score, 0);

    repeat (5) step();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_q", {q_idle, q_run, q_halt}, 3'b100);
    chk("async_x0", x0, 680);
    chk("async_x1", x1, 1000);
    chk("async_y", {y0, y1}, {10'd120, 10'd120});
    chk("async_score", score, 0);
    chk("async_tick", tick, 0);
    step();
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 12; i++) begin
      start = vecs[i].start;
      ack   = vecs[i].ack;
      lose  = vecs[i].lose;
      step();
      start = 1'b0; ack = 1'b0; lose = 1'b0;
      chk($sformatf("fsm_vec%0d", i), {q_idle, q_run, q_halt}, vecs[i].exp_q);
    end

    n = 0;
    while (s_score !== 8'd255 && n < 8000) begin
      step();
      n++;
    end
    repeat (100) step();
    chk("score_saturate", s_score, 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
